// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, raster region encoding and colour-bar helpers for the VGA timing block.
// Default build has no pattern output; VGA_TEST_PATTERN_EN adds the colour-bar generator in the top.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef enum logic [1:0] {
        RGN_ACTIVE      = 2'd0,
        RGN_FRONT_PORCH = 2'd1,
        RGN_SYNC        = 2'd2,
        RGN_BACK_PORCH  = 2'd3
    } region_e;

    localparam int BAR_W     = 80;
    localparam int BAR_COUNT = 8;

    // {r,g,b} on/off per bar, left to right
    localparam logic [2:0] BAR_WHITE   = 3'b111;
    localparam logic [2:0] BAR_YELLOW  = 3'b110;
    localparam logic [2:0] BAR_CYAN    = 3'b011;
    localparam logic [2:0] BAR_GREEN   = 3'b010;
    localparam logic [2:0] BAR_MAGENTA = 3'b101;
    localparam logic [2:0] BAR_RED     = 3'b100;
    localparam logic [2:0] BAR_BLUE    = 3'b001;
    localparam logic [2:0] BAR_BLACK   = 3'b000;

    // x/80 without a divider: compare chain against bar boundaries
    function automatic logic [2:0] bar_index(input logic [COORD_W-1:0] x);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < BAR_COUNT; i++) begin
            if (x >= COORD_W'(i * BAR_W)) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus active/sync region decode.
// Latency: count registered; wrap/in_active/in_sync combinational from count. Holds while advance is low.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
) (
    input  logic               clk_25,
    input  logic               reset_n,
    input  logic               advance,
    output logic [COORD_W-1:0] count,
    output logic               wrap,
    output logic               in_active,
    output logic               in_sync
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [COORD_W-1:0] LAST     = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] ACT_END  = COORD_W'(ACTIVE);
    localparam logic [COORD_W-1:0] SYNC_LO  = COORD_W'(ACTIVE + FP);
    localparam logic [COORD_W-1:0] SYNC_HI  = COORD_W'(ACTIVE + FP + SYNC);

    region_e region;

    always_comb begin
        if (count < ACT_END) begin
            region = RGN_ACTIVE;
        end else if (count < SYNC_LO) begin
            region = RGN_FRONT_PORCH;
        end else if (count < SYNC_HI) begin
            region = RGN_SYNC;
        end else begin
            region = RGN_BACK_PORCH;
        end
    end

    assign in_active = (region == RGN_ACTIVE);
    assign in_sync   = (region == RGN_SYNC);
    assign wrap      = advance && (count == LAST);

    always_ff @(posedge clk_25) begin
        if (!reset_n) begin
            count <= '0;
        end else if (advance) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: syncs, display enable, coordinates and line/frame strobes. 1-cycle registered latency.
// pix_en low freezes counters and outputs (strobes drop to 0); VGA_TEST_PATTERN_EN adds 8-bar rgb outputs.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE    = vga_timing_pkg::H_ACTIVE_DEF,
    parameter int   H_FP        = vga_timing_pkg::H_FP_DEF,
    parameter int   H_SYNC      = vga_timing_pkg::H_SYNC_DEF,
    parameter int   H_BP        = vga_timing_pkg::H_BP_DEF,
    parameter int   V_ACTIVE    = vga_timing_pkg::V_ACTIVE_DEF,
    parameter int   V_FP        = vga_timing_pkg::V_FP_DEF,
    parameter int   V_SYNC      = vga_timing_pkg::V_SYNC_DEF,
    parameter int   V_BP        = vga_timing_pkg::V_BP_DEF,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic               clk_25,
    input  logic               reset_n,
    input  logic               pix_en,
    output logic               h_sync,
    output logic               v_sync,
    output logic               disp_en,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               line_start,
    output logic               frame_start
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [3:0]         rgb_r,
    output logic [3:0]         rgb_g,
    output logic [3:0]         rgb_b
`endif
);

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               h_wrap;
    logic               h_in_active;
    logic               h_in_sync;
    logic               v_wrap_unused;
    logic               v_in_active;
    logic               v_in_sync;
    logic               vis_next;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk_25    (clk_25),
        .reset_n   (reset_n),
        .advance   (pix_en),
        .count     (h_cnt),
        .wrap      (h_wrap),
        .in_active (h_in_active),
        .in_sync   (h_in_sync)
    );

    // The vertical axis steps once per completed line
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk_25    (clk_25),
        .reset_n   (reset_n),
        .advance   (h_wrap),
        .count     (v_cnt),
        .wrap      (v_wrap_unused),
        .in_active (v_in_active),
        .in_sync   (v_in_sync)
    );

    assign vis_next = h_in_active && v_in_active;

    // Outputs capture the counter position being left on each enabled edge
    always_ff @(posedge clk_25) begin
        if (!reset_n) begin
            h_sync      <= ~SYNC_ACTIVE;
            v_sync      <= ~SYNC_ACTIVE;
            disp_en     <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            h_sync      <= h_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            v_sync      <= v_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            disp_en     <= vis_next;
            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_col;

    always_comb begin
        bar_col = bar_rgb(bar_index(h_cnt));
    end

    always_ff @(posedge clk_25) begin
        if (!reset_n) begin
            rgb_r <= 4'h0;
            rgb_g <= 4'h0;
            rgb_b <= 4'h0;
        end else if (pix_en) begin
            rgb_r <= vis_next ? {4{bar_col[2]}} : 4'h0;
            rgb_g <= vis_next ? {4{bar_col[1]}} : 4'h0;
            rgb_b <= vis_next ? {4{bar_col[0]}} : 4'h0;
        end
    end
`endif

endmodule
